// File: rtl/l2_request_arbiter_pkg.sv
// Shared field widths and helpers for the L2 request arbiter and its
// round-robin sub-arbiter.
package l2_request_arbiter_pkg;
    localparam int UNIT_W   = 2;
    localparam int STRAND_W = 2;
    localparam int OP_W     = 3;
    localparam int WAY_W    = 2;
    localparam int ADDR_W   = 26;
    localparam int DATA_W   = 512;
    localparam int MASK_W   = 64;

    // A single-port arbiter still needs a 1-bit pointer.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/l2_request_arbiter_if.sv
// Core request ports, system-memory restart port and the registered request
// bus of the L2 front-end arbiter.
interface l2_request_arbiter_if #(
    parameter int NUM_REQUESTERS = 4
);
    import l2_request_arbiter_pkg::*;

    // valid/ready: a request is consumed in exactly the cycle its ack is high;
    // the source holds its fields stable until then and may drop valid instead.
    logic                               stall_pipeline;
    logic [NUM_REQUESTERS-1:0]          req_valid;
    logic [STRAND_W*NUM_REQUESTERS-1:0] req_strand;
    logic [OP_W*NUM_REQUESTERS-1:0]     req_op;
    logic [WAY_W*NUM_REQUESTERS-1:0]    req_way;
    logic [ADDR_W*NUM_REQUESTERS-1:0]   req_address;
    logic [DATA_W*NUM_REQUESTERS-1:0]   req_data;
    logic [MASK_W*NUM_REQUESTERS-1:0]   req_mask;
    logic [NUM_REQUESTERS-1:0]          req_ack;

    logic                smi_restart_valid;
    logic [UNIT_W-1:0]   smi_restart_unit;
    logic [STRAND_W-1:0] smi_restart_strand;
    logic [OP_W-1:0]     smi_restart_op;
    logic [WAY_W-1:0]    smi_restart_way;
    logic [ADDR_W-1:0]   smi_restart_address;
    logic [DATA_W-1:0]   smi_restart_data;
    logic [MASK_W-1:0]   smi_restart_mask;
    logic [DATA_W-1:0]   smi_restart_sm_data;
    logic [WAY_W-1:0]    smi_restart_fill_way;
    logic                smi_restart_ack;

    logic                arb_l2req_valid;
    logic [UNIT_W-1:0]   arb_l2req_unit;
    logic [STRAND_W-1:0] arb_l2req_strand;
    logic [OP_W-1:0]     arb_l2req_op;
    logic [WAY_W-1:0]    arb_l2req_way;
    logic [ADDR_W-1:0]   arb_l2req_address;
    logic [DATA_W-1:0]   arb_l2req_data;
    logic [MASK_W-1:0]   arb_l2req_mask;
    logic                arb_has_sm_data;
    logic [DATA_W-1:0]   arb_sm_data;
    logic [WAY_W-1:0]    arb_sm_fill_way;

    modport master (
        output stall_pipeline,
        output req_valid, req_strand, req_op, req_way, req_address, req_data, req_mask,
        input  req_ack,
        output smi_restart_valid, smi_restart_unit, smi_restart_strand, smi_restart_op,
        output smi_restart_way, smi_restart_address, smi_restart_data, smi_restart_mask,
        output smi_restart_sm_data, smi_restart_fill_way,
        input  smi_restart_ack,
        input  arb_l2req_valid, arb_l2req_unit, arb_l2req_strand, arb_l2req_op,
        input  arb_l2req_way, arb_l2req_address, arb_l2req_data, arb_l2req_mask,
        input  arb_has_sm_data, arb_sm_data, arb_sm_fill_way
    );

    modport slave (
        input  stall_pipeline,
        input  req_valid, req_strand, req_op, req_way, req_address, req_data, req_mask,
        output req_ack,
        input  smi_restart_valid, smi_restart_unit, smi_restart_strand, smi_restart_op,
        input  smi_restart_way, smi_restart_address, smi_restart_data, smi_restart_mask,
        input  smi_restart_sm_data, smi_restart_fill_way,
        output smi_restart_ack,
        output arb_l2req_valid, arb_l2req_unit, arb_l2req_strand, arb_l2req_op,
        output arb_l2req_way, arb_l2req_address, arb_l2req_data, arb_l2req_mask,
        output arb_has_sm_data, arb_sm_data, arb_sm_fill_way
    );
endinterface

// File: rtl/l2_request_arbiter_rr.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping modulo NUM_PORTS. Pointer state lives in the caller.
module rr_arbiter
    import l2_request_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PTR_W     = ptr_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [PTR_W-1:0]     grant_idx,
    output logic                 any_grant
);
    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        for (int off = 0; off < NUM_PORTS; off++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!any_grant && req[i] && (i == (int'(ptr) + off) % NUM_PORTS)) begin
                    grant[i]  = 1'b1;
                    any_grant = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) grant_idx = PTR_W'(i);
        end
    end
endmodule

// File: rtl/l2_request_arbiter.sv
// L2 pipeline front end: picks a restart (burst-limited) or a round-robin core
// request each cycle and registers it for the directory/tag stage.
module l2_request_arbiter
    import l2_request_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS    = 4,
    parameter int RESTART_BURST_MAX = 4
) (
    input logic clk,
    input logic reset,
    l2_request_arbiter_if.slave bus
);
    localparam int PTR_W   = ptr_width(NUM_REQUESTERS);
    localparam int BURST_W = $clog2(RESTART_BURST_MAX + 1);

    logic [PTR_W-1:0]          rr_ptr;
    logic [BURST_W-1:0]        burst_cnt;
    logic [NUM_REQUESTERS-1:0] core_grant;
    logic [PTR_W-1:0]          core_idx;
    logic                      core_any;
    logic                      burst_full;
    logic                      restart_win;
    logic                      core_win;

    logic [STRAND_W-1:0] core_strand;
    logic [OP_W-1:0]     core_op;
    logic [WAY_W-1:0]    core_way;
    logic [ADDR_W-1:0]   core_address;
    logic [DATA_W-1:0]   core_data;
    logic [MASK_W-1:0]   core_mask;

    logic                out_valid;
    logic [UNIT_W-1:0]   out_unit;
    logic [STRAND_W-1:0] out_strand;
    logic [OP_W-1:0]     out_op;
    logic [WAY_W-1:0]    out_way;
    logic [ADDR_W-1:0]   out_address;
    logic [DATA_W-1:0]   out_data;
    logic [MASK_W-1:0]   out_mask;
    logic                out_has_sm;
    logic [DATA_W-1:0]   out_sm_data;
    logic [WAY_W-1:0]    out_sm_fill_way;

    rr_arbiter #(.NUM_PORTS(NUM_REQUESTERS), .PTR_W(PTR_W)) u_rr (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (core_grant),
        .grant_idx (core_idx),
        .any_grant (core_any)
    );

    // Restart yields only once it has used its burst and a core is waiting.
    assign burst_full  = (burst_cnt == BURST_W'(RESTART_BURST_MAX));
    assign restart_win = bus.smi_restart_valid && !(burst_full && core_any);
    assign core_win    = !restart_win && core_any;

    assign bus.smi_restart_ack = restart_win && !bus.stall_pipeline;
    assign bus.req_ack         = (core_win && !bus.stall_pipeline) ? core_grant : '0;

    always_comb begin
        core_strand  = '0;
        core_op      = '0;
        core_way     = '0;
        core_address = '0;
        core_data    = '0;
        core_mask    = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (core_grant[i]) begin
                core_strand  = bus.req_strand[i*STRAND_W +: STRAND_W];
                core_op      = bus.req_op[i*OP_W +: OP_W];
                core_way     = bus.req_way[i*WAY_W +: WAY_W];
                core_address = bus.req_address[i*ADDR_W +: ADDR_W];
                core_data    = bus.req_data[i*DATA_W +: DATA_W];
                core_mask    = bus.req_mask[i*MASK_W +: MASK_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid       <= 1'b0;
            out_unit        <= '0;
            out_strand      <= '0;
            out_op          <= '0;
            out_way         <= '0;
            out_address     <= '0;
            out_data        <= '0;
            out_mask        <= '0;
            out_has_sm      <= 1'b0;
            out_sm_data     <= '0;
            out_sm_fill_way <= '0;
            rr_ptr          <= '0;
            burst_cnt       <= '0;
        end else if (!bus.stall_pipeline) begin
            out_valid <= restart_win || core_win;
            if (restart_win) begin
                out_unit        <= bus.smi_restart_unit;
                out_strand      <= bus.smi_restart_strand;
                out_op          <= bus.smi_restart_op;
                out_way         <= bus.smi_restart_way;
                out_address     <= bus.smi_restart_address;
                out_data        <= bus.smi_restart_data;
                out_mask        <= bus.smi_restart_mask;
                out_has_sm      <= 1'b1;
                out_sm_data     <= bus.smi_restart_sm_data;
                out_sm_fill_way <= bus.smi_restart_fill_way;
                // A winning restart with cores waiting is never at the limit.
                burst_cnt       <= core_any ? burst_cnt + 1'b1 : '0;
            end else if (core_win) begin
                out_unit        <= UNIT_W'(core_idx);
                out_strand      <= core_strand;
                out_op          <= core_op;
                out_way         <= core_way;
                out_address     <= core_address;
                out_data        <= core_data;
                out_mask        <= core_mask;
                out_has_sm      <= 1'b0;
                out_sm_data     <= '0;
                out_sm_fill_way <= '0;
                burst_cnt       <= '0;
                rr_ptr          <= (core_idx == PTR_W'(NUM_REQUESTERS - 1)) ? '0
                                                                            : core_idx + 1'b1;
            end else begin
                out_unit        <= '0;
                out_strand      <= '0;
                out_op          <= '0;
                out_way         <= '0;
                out_address     <= '0;
                out_data        <= '0;
                out_mask        <= '0;
                out_has_sm      <= 1'b0;
                out_sm_data     <= '0;
                out_sm_fill_way <= '0;
            end
        end
    end

    assign bus.arb_l2req_valid   = out_valid;
    assign bus.arb_l2req_unit    = out_unit;
    assign bus.arb_l2req_strand  = out_strand;
    assign bus.arb_l2req_op      = out_op;
    assign bus.arb_l2req_way     = out_way;
    assign bus.arb_l2req_address = out_address;
    assign bus.arb_l2req_data    = out_data;
    assign bus.arb_l2req_mask    = out_mask;
    assign bus.arb_has_sm_data   = out_has_sm;
    assign bus.arb_sm_data       = out_sm_data;
    assign bus.arb_sm_fill_way   = out_sm_fill_way;
endmodule

// File: tb/tb_l2_request_arbiter.sv
// Self-checking bench for l2_request_arbiter: directed scenarios plus random
// traffic against a transaction-level model of the grant rules.
module tb_l2_request_arbiter;
    localparam int N         = 4;
    localparam int BURST_MAX = 4;

    typedef struct packed {
        logic         valid;
        logic [1:0]   unit;
        logic [1:0]   strand;
        logic [2:0]   op;
        logic [1:0]   way;
        logic [25:0]  addr;
        logic [511:0] data;
        logic [63:0]  mask;
        logic         has_sm;
        logic [511:0] sm_data;
        logic [1:0]   fill_way;
    } out_t;
    localparam int OUT_W = $bits(out_t);

    logic clk;
    logic reset;

    l2_request_arbiter_if #(.NUM_REQUESTERS(N)) bus ();

    l2_request_arbiter #(.NUM_REQUESTERS(N), .RESTART_BURST_MAX(BURST_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus state: pending requests and their held fields.
    bit           pend [N];
    logic [1:0]   p_strand [N];
    logic [2:0]   p_op [N];
    logic [1:0]   p_way [N];
    logic [25:0]  p_addr [N];
    logic [511:0] p_data [N];
    logic [63:0]  p_mask [N];
    bit           r_pend;
    logic [1:0]   r_unit, r_strand, r_way, r_fill;
    logic [2:0]   r_op;
    logic [25:0]  r_addr;
    logic [511:0] r_data, r_sm;
    logic [63:0]  r_mask;
    bit           stall;

    // Reference model state.
    int m_ptr;
    int m_burst;
    logic [OUT_W-1:0] exp_q [$];

    int n_tests = 0;
    int n_fail  = 0;
    int g;
    logic [511:0] a5;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic drive();
        bus.stall_pipeline = stall;
        for (int p = 0; p < N; p++) begin
            bus.req_valid[p]             = pend[p];
            bus.req_strand[p*2 +: 2]     = p_strand[p];
            bus.req_op[p*3 +: 3]         = p_op[p];
            bus.req_way[p*2 +: 2]        = p_way[p];
            bus.req_address[p*26 +: 26]  = p_addr[p];
            bus.req_data[p*512 +: 512]   = p_data[p];
            bus.req_mask[p*64 +: 64]     = p_mask[p];
        end
        bus.smi_restart_valid    = r_pend;
        bus.smi_restart_unit     = r_unit;
        bus.smi_restart_strand   = r_strand;
        bus.smi_restart_op       = r_op;
        bus.smi_restart_way      = r_way;
        bus.smi_restart_address  = r_addr;
        bus.smi_restart_data     = r_data;
        bus.smi_restart_mask     = r_mask;
        bus.smi_restart_sm_data  = r_sm;
        bus.smi_restart_fill_way = r_fill;
    endtask

    task automatic set_port(input int p, input logic [25:0] addr);
        pend[p]     = 1'b1;
        p_strand[p] = 2'($urandom);
        p_op[p]     = 3'($urandom);
        p_way[p]    = 2'($urandom);
        p_addr[p]   = addr;
        p_data[p]   = rand512();
        p_mask[p]   = {$urandom, $urandom};
    endtask

    task automatic set_restart(input logic [511:0] sm, input logic [1:0] fill);
        r_pend   = 1'b1;
        r_unit   = 2'($urandom);
        r_strand = 2'($urandom);
        r_op     = 3'($urandom);
        r_way    = 2'($urandom);
        r_addr   = 26'($urandom);
        r_data   = rand512();
        r_mask   = {$urandom, $urandom};
        r_sm     = sm;
        r_fill   = fill;
    endtask

    task automatic rand_inputs(input int p_new, input int p_wd, input int p_rst, input int p_stall);
        for (int p = 0; p < N; p++) begin
            if (pend[p]) begin
                if ($urandom_range(99) < p_wd) pend[p] = 1'b0;
            end else if ($urandom_range(99) < p_new) begin
                set_port(p, 26'($urandom));
            end
        end
        if (r_pend) begin
            if ($urandom_range(99) < p_wd) r_pend = 1'b0;
        end else if ($urandom_range(99) < p_rst) begin
            set_restart(rand512(), 2'($urandom));
        end
        stall = ($urandom_range(99) < p_stall);
    endtask

    // One clock: drive, check acks and registered outputs at negedge,
    // advance the model, return at posedge+1. dut_gnt: port, N=restart, -1=none.
    task automatic cycle(output int dut_gnt);
        out_t       e;
        out_t       nx;
        int         gnt;
        int         p;
        bit         any_core;
        logic [N-1:0] ea;
        drive();
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 1'b1, 1'b0);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        check("valid",    bus.arb_l2req_valid,   e.valid);
        check("unit",     bus.arb_l2req_unit,    e.unit);
        check("strand",   bus.arb_l2req_strand,  e.strand);
        check("op",       bus.arb_l2req_op,      e.op);
        check("way",      bus.arb_l2req_way,     e.way);
        check("address",  bus.arb_l2req_address, e.addr);
        check("data",     bus.arb_l2req_data,    e.data);
        check("mask",     bus.arb_l2req_mask,    e.mask);
        check("has_sm",   bus.arb_has_sm_data,   e.has_sm);
        check("sm_data",  bus.arb_sm_data,       e.sm_data);
        check("fill_way", bus.arb_sm_fill_way,   e.fill_way);

        any_core = 1'b0;
        for (int i = 0; i < N; i++) any_core |= pend[i];
        gnt = -1;
        if (!stall) begin
            if (r_pend && !(m_burst == BURST_MAX && any_core)) begin
                gnt = N;
            end else begin
                for (int off = 0; off < N; off++) begin
                    p = (m_ptr + off) % N;
                    if (gnt < 0 && pend[p]) gnt = p;
                end
            end
        end
        ea = '0;
        if (gnt >= 0 && gnt < N) ea[gnt] = 1'b1;
        check("req_ack",     bus.req_ack,         ea);
        check("restart_ack", bus.smi_restart_ack, gnt == N);

        dut_gnt = -1;
        if (bus.smi_restart_ack) dut_gnt = N;
        else for (int i = N - 1; i >= 0; i--) if (bus.req_ack[i]) dut_gnt = i;

        nx = e;
        if (!stall) begin
            nx = '0;
            if (gnt == N) begin
                nx.valid = 1'b1;    nx.unit = r_unit;   nx.strand = r_strand;
                nx.op = r_op;       nx.way = r_way;     nx.addr = r_addr;
                nx.data = r_data;   nx.mask = r_mask;   nx.has_sm = 1'b1;
                nx.sm_data = r_sm;  nx.fill_way = r_fill;
                m_burst = any_core ? ((m_burst < BURST_MAX) ? m_burst + 1 : m_burst) : 0;
                r_pend = 1'b0;
            end else if (gnt >= 0) begin
                nx.valid = 1'b1;          nx.unit = 2'(gnt);      nx.strand = p_strand[gnt];
                nx.op = p_op[gnt];        nx.way = p_way[gnt];    nx.addr = p_addr[gnt];
                nx.data = p_data[gnt];    nx.mask = p_mask[gnt];
                m_ptr   = (gnt + 1) % N;
                m_burst = 0;
                pend[gnt] = 1'b0;
            end
        end
        exp_q.push_back(nx);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0;
        r_pend = 1'b0;
        for (int p = 0; p < N; p++) pend[p] = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_ptr = 0;
        m_burst = 0;
        exp_q.delete();
        exp_q.push_back('0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a5 = {64{8'hA5}};
        for (int p = 0; p < N; p++) set_port(p, '0);
        set_restart('0, '0);
        do_reset();

        // Single port 2 LOAD.
        set_port(2, 26'h0000123);
        p_op[2] = 3'd0;
        cycle(g);
        check("t1_gnt", g, 2);
        check("t1_valid", bus.arb_l2req_valid, 1'b1);
        check("t1_unit", bus.arb_l2req_unit, 2'd2);
        check("t1_addr", bus.arb_l2req_address, 26'h0000123);
        check("t1_has_sm", bus.arb_has_sm_data, 1'b0);

        // All ports valid from rr_ptr=0: 0,1,2,3,0.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            for (int p = 0; p < N; p++) if (!pend[p]) set_port(p, 26'($urandom));
            cycle(g);
            check("rr_order", g, k % N);
        end

        // Mid-cycle async reset with a valid request registered.
        #2 reset = 1'b1;
        #1;
        check("arst_valid", bus.arb_l2req_valid, 1'b0);
        check("arst_unit", bus.arb_l2req_unit, 2'd0);
        check("arst_addr", bus.arb_l2req_address, 26'd0);
        check("arst_data", bus.arb_l2req_data, 512'd0);
        do_reset();
        set_port(1, 26'h0000ABC);
        set_port(3, 26'h0000DEF);
        cycle(g);
        check("arst_first", g, 1);

        // Restart burst limit against a waiting port 1.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            set_restart(a5, 2'd3);
            if (!pend[1]) set_port(1, 26'($urandom));
            cycle(g);
            check("burst_seq", g, (k % 5 == 4) ? 1 : N);
            if (k == 0) begin
                check("burst_has_sm", bus.arb_has_sm_data, 1'b1);
                check("burst_fill", bus.arb_sm_fill_way, 2'd3);
                check("burst_sm", bus.arb_sm_data, a5);
            end
        end

        // Stall 3 cycles under contention, then the same winner resumes.
        do_reset();
        for (int p = 0; p < N; p++) set_port(p, 26'($urandom));
        cycle(g);
        check("stall_pre", g, 0);
        set_port(0, 26'($urandom));
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle(g);
            check("stall_gnt", g, -1);
        end
        stall = 1'b0;
        cycle(g);
        check("stall_post", g, 1);

        // Idle.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            cycle(g);
            check("idle_gnt", g, -1);
        end
        check("idle_valid", bus.arb_l2req_valid, 1'b0);

        // Random traffic.
        do_reset();
        for (int c = 0; c < 700; c++) begin rand_inputs(60, 5, 50, 10); cycle(g); end
        for (int c = 0; c < 500; c++) begin rand_inputs(90, 0, 90, 0);  cycle(g); end
        for (int c = 0; c < 500; c++) begin rand_inputs(30, 10, 20, 30); cycle(g); end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
